// File: rtl/wb_pkg.sv
`timescale 1ns/1ps
// wb_pkg: shared writeback encodings, FSM states and grant sources
package wb_pkg;
    localparam int REGWRITE_BIT = 1;
    localparam int MEMTOREG_BIT = 0;
    typedef enum logic {ARB_NORMAL = 1'b0, ARB_DRAIN = 1'b1} arb_state_t;
    localparam logic SRC_PIPE = 1'b0;
    localparam logic SRC_MDU  = 1'b1;
endpackage

// File: rtl/wb_mdu_fifo.sv
`timescale 1ns/1ps
// wb_mdu_fifo: 2-entry synchronous FIFO holding out-of-band MDU results
module wb_mdu_fifo #(
    parameter int W = 37
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] mem_q [2];
    logic         wr_q;
    logic         rd_q;
    logic [1:0]   count_q;
    // pointers wrap modulo 2; push and pop together leave the count unchanged
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            count_q <= 2'd0;
        end else begin
            wr_q    <= wr_q ^ push_i;
            rd_q    <= rd_q ^ pop_i;
            count_q <= count_q + 2'(push_i) - 2'(pop_i);
        end
    // storage needs no reset: the count gates what is ever read out
    always_ff @(posedge clk)
        if (push_i) mem_q[wr_q] <= din_i;
    assign dout_o  = mem_q[rd_q];
    assign count_o = count_q;
endmodule

// File: rtl/wb_write_arbiter.sv
`timescale 1ns/1ps
// wb_write_arbiter: shares the register-file write port between pipeline writeback and MDU results
// Optional WB_MDU_BYPASS_EN: MDU result into an empty FIFO with no pipe request is written directly
module wb_write_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_valid,
    input  logic [1:0]        pipe_wb_control,
    input  logic [DATA_W-1:0] pipe_alu_result,
    input  logic [DATA_W-1:0] pipe_mem_read_data,
    input  logic [ADDR_W-1:0] pipe_rd,
    input  logic              mdu_valid,
    output logic              mdu_ready,
    input  logic [ADDR_W-1:0] mdu_rd,
    input  logic [DATA_W-1:0] mdu_data,
    output logic              stall_req,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              grant_src
);
    localparam int EW = ADDR_W + DATA_W;

    arb_state_t        state_q;
    logic [3:0]        starve_q;
    logic              drain_cnt_q;
    logic              rf_we_q;
    logic [ADDR_W-1:0] rf_waddr_q;
    logic [DATA_W-1:0] rf_wdata_q;
    logic              grant_src_q;

    logic              pipe_req;
    logic [DATA_W-1:0] pipe_data;
    logic [1:0]        fifo_count;
    logic [1:0]        count_after;
    logic [EW-1:0]     fifo_dout;
    logic [ADDR_W-1:0] fifo_rd;
    logic [DATA_W-1:0] fifo_data;
    logic              normal;
    logic              fifo_empty;
    logic              push_ok;
    logic              bypass;
    logic              fifo_push;
    logic              fifo_pop;
    logic              grant_pipe;
    logic              grant_any;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;
    logic              starve_inc;
    logic              starve_hit;
    logic              drain_exit;

    wb_mdu_fifo #(.W(EW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   ({mdu_rd, mdu_data}),
        .dout_o  (fifo_dout),
        .count_o (fifo_count)
    );

    // request decode, writeback mux and grant selection for the current cycle
    always_comb begin
        normal      = state_q == ARB_NORMAL;
        fifo_empty  = fifo_count == 2'd0;
        mdu_ready   = fifo_count != 2'd2;
        push_ok     = mdu_valid & mdu_ready;
        pipe_req    = pipe_valid & pipe_wb_control[REGWRITE_BIT] & (pipe_rd != '0);
        pipe_data   = pipe_wb_control[MEMTOREG_BIT] ? pipe_mem_read_data : pipe_alu_result;
`ifdef WB_MDU_BYPASS_EN
        bypass      = normal & fifo_empty & ~pipe_req & push_ok;
`else
        bypass      = 1'b0;
`endif
        fifo_push   = push_ok & ~bypass;
        grant_pipe  = normal & pipe_req;
        fifo_pop    = ~fifo_empty & ~grant_pipe;
        grant_any   = grant_pipe | fifo_pop | bypass;
        {fifo_rd, fifo_data} = fifo_dout;
        sel_rd      = grant_pipe ? pipe_rd : bypass ? mdu_rd : fifo_rd;
        sel_data    = grant_pipe ? pipe_data : bypass ? mdu_data : fifo_data;
        count_after = fifo_count - 2'(fifo_pop) + 2'(fifo_push);
        starve_inc  = grant_pipe & ~fifo_empty;
        starve_hit  = starve_inc & (starve_q + 4'd1 == 4'(STARVE_LIMIT));
        drain_exit  = (count_after == 2'd0) | drain_cnt_q;
    end

    // FSM, starvation counter and registered write port
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q     <= ARB_NORMAL;
            starve_q    <= 4'd0;
            drain_cnt_q <= 1'b0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            grant_src_q <= SRC_PIPE;
        end else begin
            rf_we_q <= grant_any & (sel_rd != '0);
            if (grant_any & (sel_rd != '0)) begin
                rf_waddr_q  <= sel_rd;
                rf_wdata_q  <= sel_data;
                grant_src_q <= grant_pipe ? SRC_PIPE : SRC_MDU;
            end
            if (normal) begin
                starve_q    <= (starve_inc & ~starve_hit) ? starve_q + 4'd1 : 4'd0;
                state_q     <= starve_hit ? ARB_DRAIN : ARB_NORMAL;
                drain_cnt_q <= 1'b0;
            end else begin
                starve_q    <= 4'd0;
                state_q     <= drain_exit ? ARB_NORMAL : ARB_DRAIN;
                drain_cnt_q <= ~drain_exit;
            end
        end

    assign stall_req = state_q == ARB_DRAIN;
    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign grant_src = grant_src_q;
endmodule

// File: tb/tb_wb_write_arbiter.sv
`timescale 1ns/1ps
// tb_wb_write_arbiter: directed and random stimulus against a queue-based reference model with a write scoreboard
module tb_wb_write_arbiter;
    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pipe_valid = 1'b0;
    logic [1:0]    pipe_wb_control = 2'b00;
    logic [DW-1:0] pipe_alu_result = '0;
    logic [DW-1:0] pipe_mem_read_data = '0;
    logic [AW-1:0] pipe_rd = '0;
    logic          mdu_valid = 1'b0;
    logic          mdu_ready;
    logic [AW-1:0] mdu_rd = '0;
    logic [DW-1:0] mdu_data = '0;
    logic          stall_req;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          grant_src;

    always #5 clk = ~clk;

    wb_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
        .clk                (clk),
        .rst                (rst),
        .pipe_valid         (pipe_valid),
        .pipe_wb_control    (pipe_wb_control),
        .pipe_alu_result    (pipe_alu_result),
        .pipe_mem_read_data (pipe_mem_read_data),
        .pipe_rd            (pipe_rd),
        .mdu_valid          (mdu_valid),
        .mdu_ready          (mdu_ready),
        .mdu_rd             (mdu_rd),
        .mdu_data           (mdu_data),
        .stall_req          (stall_req),
        .rf_we              (rf_we),
        .rf_waddr           (rf_waddr),
        .rf_wdata           (rf_wdata),
        .grant_src          (grant_src)
    );

    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; logic s; } wr_t;
    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } mdu_t;

    int   checks = 0;
    int   errors = 0;
    wr_t  exp_q[$];
    mdu_t mq[$];
    bit   m_drain = 0;
    int   m_starve = 0;
    int   m_dgr = 0;
    bit   m_we = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int   n = mq.size();
        bit   push = mdu_valid && n < 2;
        bit   preq = !m_drain && pipe_valid && pipe_wb_control[1] && pipe_rd != 0;
        mdu_t e;
        m_we = 0;
        if (m_drain) begin
            e = mq.pop_front();
            m_we = e.a != 0;
            if (m_we) exp_q.push_back(wr_t'{e.a, e.d, 1'b1});
            m_dgr++;
            if (mq.size() + int'(push) == 0 || m_dgr == 2) begin
                m_drain = 0;
                m_dgr = 0;
            end
            m_starve = 0;
        end else begin
`ifdef WB_MDU_BYPASS_EN
            if (push && n == 0 && !preq) begin
                push = 0;
                m_we = mdu_rd != 0;
                if (m_we) exp_q.push_back(wr_t'{mdu_rd, mdu_data, 1'b1});
                m_starve = 0;
            end else
`endif
            if (preq) begin
                m_we = 1;
                exp_q.push_back(wr_t'{pipe_rd, pipe_wb_control[0] ? pipe_mem_read_data : pipe_alu_result, 1'b0});
                if (n > 0) begin
                    m_starve++;
                    if (m_starve == LIM) begin
                        m_drain = 1;
                        m_starve = 0;
                    end
                end else m_starve = 0;
            end else if (n > 0) begin
                e = mq.pop_front();
                m_we = e.a != 0;
                if (m_we) exp_q.push_back(wr_t'{e.a, e.d, 1'b1});
                m_starve = 0;
            end else m_starve = 0;
        end
        if (push) mq.push_back(mdu_t'{mdu_rd, mdu_data});
    endtask

    task automatic monitor_step();
        wr_t w;
        chk("stall_req", stall_req, m_drain);
        chk("mdu_ready", mdu_ready, mq.size() != 2);
        chk("rf_we", rf_we, m_we);
        if (m_we) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: write expected but queue empty");
            end else begin
                w = exp_q.pop_front();
                chk("rf_waddr", rf_waddr, w.a);
                chk("rf_wdata", rf_wdata, w.d);
                chk("grant_src", grant_src, w.s);
            end
        end
    endtask

    // reference model advances on every edge the DUT sees
    always @(posedge clk or posedge rst)
        if (rst) begin
            mq.delete();
            exp_q.delete();
            m_drain = 0;
            m_starve = 0;
            m_dgr = 0;
            m_we = 0;
        end else model_step();

    // monitor compares the DUT's registered outputs mid-cycle
    always @(negedge clk)
        if (!rst) monitor_step();

    task automatic cyc(input bit pv, input logic [1:0] wb, input logic [DW-1:0] alu, input logic [DW-1:0] mem,
                       input logic [AW-1:0] rd, input bit mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md);
        pipe_valid = pv;
        pipe_wb_control = wb;
        pipe_alu_result = alu;
        pipe_mem_read_data = mem;
        pipe_rd = rd;
        mdu_valid = mv;
        mdu_rd = mrd;
        mdu_data = md;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 2'b00, '0, '0, '0, 0, '0, '0);
    endtask

    initial begin
        bit            prev_stall;
        logic [1:0]    wb;
        logic [DW-1:0] alu;
        logic [DW-1:0] mem;
        logic [AW-1:0] rd;
        bit            pv;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_grant_src", grant_src, 0);
        chk("rst_stall_req", stall_req, 0);
        rst = 1'b0;
        #1;
        chk("rst_mdu_ready", mdu_ready, 1);
        @(posedge clk);
        #1;

        cyc(1, 2'b10, 32'h12345678, 32'h0, 5'd3, 0, '0, '0);
        chk("tp1_we", rf_we, 1);
        chk("tp1_waddr", rf_waddr, 3);
        chk("tp1_wdata", rf_wdata, 32'h12345678);
        chk("tp1_src", grant_src, 0);
        cyc(1, 2'b11, 32'h11111111, 32'hCAFEBABE, 5'd7, 0, '0, '0);
        chk("tp2_load", rf_wdata, 32'hCAFEBABE);
        cyc(1, 2'b01, 32'h1, 32'h2, 5'd7, 0, '0, '0);
        chk("tp2_noregwrite", rf_we, 0);
        cyc(1, 2'b10, 32'h1, 32'h2, 5'd0, 0, '0, '0);
        chk("tp2_rd0", rf_we, 0);

        cyc(0, 2'b00, '0, '0, '0, 1, 5'd9, 32'hDEADBEEF);
`ifndef WB_MDU_BYPASS_EN
        chk("tp3_not_yet", rf_we, 0);
        idle(1);
`endif
        chk("tp3_we", rf_we, 1);
        chk("tp3_waddr", rf_waddr, 9);
        chk("tp3_wdata", rf_wdata, 32'hDEADBEEF);
        chk("tp3_src", grant_src, 1);
        idle(2);

        cyc(1, 2'b10, 32'hA0, '0, 5'd1, 1, 5'd20, 32'h5150);
        for (int k = 1; k <= 4; k++) begin
            chk("tp4_no_stall", stall_req, 0);
            cyc(1, 2'b10, 32'hA0 + k, '0, 5'(k + 1), 0, '0, '0);
        end
        chk("tp4_stall", stall_req, 1);
        cyc(1, 2'b10, 32'hB0, '0, 5'd10, 0, '0, '0);
        chk("tp4_mdu_we", rf_we, 1);
        chk("tp4_mdu_addr", rf_waddr, 20);
        chk("tp4_mdu_src", grant_src, 1);
        chk("tp4_unstall", stall_req, 0);
        cyc(1, 2'b10, 32'hB0, '0, 5'd10, 0, '0, '0);
        chk("tp4_held_addr", rf_waddr, 10);
        chk("tp4_held_src", grant_src, 0);
        idle(2);

        cyc(1, 2'b10, 32'hC0, '0, 5'd4, 1, 5'd11, 32'h0B0B);
        cyc(1, 2'b10, 32'hC1, '0, 5'd5, 1, 5'd12, 32'h0C0C);
        chk("tp5_full", mdu_ready, 0);
        cyc(1, 2'b10, 32'hC2, '0, 5'd6, 1, 5'd13, 32'h0D0D);
        idle(6);

        cyc(1, 2'b10, 32'hD0, '0, 5'd4, 1, 5'd14, 32'h0E0E);
        cyc(1, 2'b10, 32'hD1, '0, 5'd5, 1, 5'd15, 32'h0F0F);
        cyc(1, 2'b10, 32'hD2, '0, 5'd6, 0, '0, '0);
        cyc(1, 2'b10, 32'hD3, '0, 5'd7, 0, '0, '0);
        cyc(1, 2'b10, 32'hD4, '0, 5'd8, 0, '0, '0);
        chk("tp6_drain", stall_req, 1);
        chk("tp6_full", mdu_ready, 0);
        #2 rst = 1'b1;
        #1;
        chk("tp6_rf_we", rf_we, 0);
        chk("tp6_rf_waddr", rf_waddr, 0);
        chk("tp6_rf_wdata", rf_wdata, 0);
        chk("tp6_grant_src", grant_src, 0);
        chk("tp6_stall", stall_req, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("tp6_ready", mdu_ready, 1);
        idle(4);
        chk("tp6_no_stale", rf_we, 0);

        prev_stall = 0;
        pv = 0; wb = 0; alu = 0; mem = 0; rd = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!prev_stall) begin
                pv  = $urandom_range(0, 3) != 0;
                wb  = 2'($urandom);
                alu = $urandom;
                mem = $urandom;
                rd  = 5'($urandom);
            end
            prev_stall = stall_req;
            cyc(pv, wb, alu, mem, rd, $urandom_range(0, 4) < 2, 5'($urandom), $urandom);
        end
        idle(8);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Shares the single register-file write port between the pipeline writeback path and a multi-cycle unit (MDU: multiply/divide) that returns results out of band. The block sits after the MEM/WB pipeline register and feeds the register file. It performs the writeback select (MemToReg mux) for the pipeline and buffers MDU results in a 2-entry FIFO. A starvation counter with a drain state machine guarantees MDU forward progress by stalling the pipeline.

## Interface
Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- STARVE_LIMIT, 4, consecutive lost cycles before a forced drain (legal range 1..15)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- pipe_valid  in  1  MEM/WB slot holds a real instruction
- pipe_wb_control  in  2  {RegWrite, MemToReg}
- pipe_alu_result  in  DATA_W  ALU result
- pipe_mem_read_data  in  DATA_W  load data
- pipe_rd  in  ADDR_W  destination register
- mdu_valid  in  1  MDU result offered
- mdu_ready  out  1  FIFO can accept; equals (fifo_count != 2)
- mdu_rd  in  ADDR_W  MDU destination register
- mdu_data  in  DATA_W  MDU result
- stall_req  out  1  pipeline must hold MEM/WB contents this cycle
- rf_we  out  1  registered write enable
- rf_waddr  out  ADDR_W  registered write address
- rf_wdata  out  DATA_W  registered write data
- grant_src  out  1  registered source of the last write: 0 = pipe, 1 = MDU

## Operation
- Pipe request: pipe_req = pipe_valid & RegWrite & (pipe_rd != 0). Pipe data = MemToReg ? pipe_mem_read_data : pipe_alu_result.
- MDU push occurs when mdu_valid & mdu_ready. An entry with mdu_rd == 0 is accepted and then discarded at pop, with rf_we = 0.
- FIFO: 2 entries, count 0..2, pointers wrap modulo 2. Push and pop may occur in the same cycle when count = 1, and the count is unchanged.
- FSM states:
  - NORMAL:
    - If pipe_req, grant pipe.
    - Else if the FIFO is non-empty, grant MDU (pop).
    - Else no write.
  - DRAIN:
    - stall_req = 1; pipe inputs are ignored.
    - Grant MDU (pop) each cycle.
- Starvation counter (4 bits):
  - In NORMAL, increments on each cycle where the FIFO is non-empty and the pipe is granted.
  - Clears on any MDU grant or when the FIFO is empty.
- NORMAL -> DRAIN: at the edge where the counter would reach STARVE_LIMIT.
- DRAIN -> NORMAL: at the edge where the pop leaves the FIFO empty, or after 2 consecutive DRAIN grants, whichever comes first.
- Pushes remain legal during DRAIN.
- A pipe request seen while stall_req = 1 is not consumed. The pipeline presents the same request the next cycle.

## Timing
- Reset values:
  - rf_we = 0, rf_waddr = 0, rf_wdata = 0, grant_src = 0, stall_req = 0.
  - FSM = NORMAL, FIFO empty, counter = 0.
  - mdu_ready = 1 once rst is deasserted.
- Pipe latency: 1 cycle. Inputs in cycle N appear on rf_* after the edge ending cycle N.
- MDU latency: minimum 2 cycles from push to rf_we, since the entry is pushed in cycle N, popped in N+1, and visible after that edge.
- stall_req is a decode of registered FSM state only. It has no combinational path from inputs.
- Reset mid-operation: FIFO contents and the pending grant are discarded. Outputs go to reset values immediately (asynchronously).
- At most one write per cycle. rf_we is never asserted with rf_waddr = 0.

## Configuration
- WB_MDU_BYPASS_EN
  - Defined: an MDU push arriving when the FIFO is empty, pipe_req = 0 and state = NORMAL is written directly in that cycle with 1-cycle latency, and is not enqueued.
  - Undefined: every MDU result passes through the FIFO, with minimum latency 2.

## Structure
- Shared package wb_pkg:
  - wb_control bit indices (REGWRITE_BIT = 1, MEMTOREG_BIT = 0).
  - FSM state enum (ARB_NORMAL, ARB_DRAIN).
  - grant_src encodings (SRC_PIPE = 0, SRC_MDU = 1).
- One sub-module: wb_mdu_fifo, a 2-entry synchronous FIFO with push/pop/count and asynchronous reset. Arbitration, FSM and output registers stay in the top.

## Test plan
- Reset released, pipe_wb_control = 2'b10, pipe_rd = 3, pipe_alu_result = 32'h12345678 -> next cycle rf_we = 1, rf_waddr = 3, rf_wdata = 32'h12345678, grant_src = 0.
- pipe_wb_control = 2'b11, pipe_mem_read_data = 32'hCAFEBABE, rd = 7 -> rf_wdata = 32'hCAFEBABE. With 2'b01 -> rf_we = 0. With 2'b10 and rd = 0 -> rf_we = 0.
- Pipe idle, MDU push rd = 9, data = 32'hDEADBEEF in cycle 0 -> rf write of rd 9 with grant_src = 1 after cycle 1 (after cycle 0 with WB_MDU_BYPASS_EN defined).
- MDU push in cycle 0 and pipe_req every cycle with STARVE_LIMIT = 4 -> pipe wins cycles 1–4, stall_req = 1 in cycle 5, MDU is written, and the held pipe request is written in cycle 6.
- Two MDU pushes back-to-back while the pipe is busy -> mdu_ready = 0 with count = 2, a third offer is refused until a pop, and no entry is lost or reordered.
- Assert rst while count = 2 and in DRAIN -> outputs zero immediately. After release: NORMAL, FIFO empty, mdu_ready = 1, no stale write.
